// File: rtl/dl_detect_pkg.sv
// Shared definitions for the deadlock circle detector: FSM encoding and
// a lowest-set-bit isolator used when following wait-for edges.
package dl_detect_pkg;

    localparam int MAX_PROC = 32;

    typedef enum logic [1:0] {
        S_MONITOR = 2'd0,
        S_SCAN    = 2'd1,
        S_FLAG    = 2'd2,
        S_WALK    = 2'd3
    } dl_state_t;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [MAX_PROC-1:0] first_one_hot(input logic [MAX_PROC-1:0] v);
        first_one_hot = v & (~v + {{(MAX_PROC-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/dl_stall_counter.sv
// Per-process watchdog: counts consecutive blocked cycles, saturating at
// STALL_CYCLES, and raises a registered stalled flag on reaching it.
module dl_stall_counter #(
    parameter int STALL_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic blocked,
    input  logic freeze,
    output logic stalled
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            stalled <= 1'b0;
        end else if (!freeze) begin
            if (!blocked) begin
                count   <= '0;
                stalled <= 1'b0;
            end else if (count != LIMIT) begin
                count   <= count + CNT_W'(1);
                stalled <= (count + CNT_W'(1) == LIMIT);
            end
        end
    end

endmodule

// File: rtl/dl_stall_cycle_detector.sv
// Finds stalled processes lying on a closed wait-for circle, flags them for
// one cycle, then walks the circle one hop per cycle from a chosen origin.
module dl_stall_cycle_detector
    import dl_detect_pkg::*;
#(
    parameter int PROC_NUM     = 2,
    parameter int STALL_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PROC_NUM-1:0]          proc_blocked,
    input  logic [PROC_NUM*PROC_NUM-1:0] dep_vec,
    input  logic [PROC_NUM-1:0]          origin,
    input  logic                         token_clear,
    output logic [PROC_NUM-1:0]          dl_in_vec,
    output logic [PROC_NUM-1:0]          stall_vec,
    output logic                         scan_busy
);

    localparam int CIDX_W = $clog2(PROC_NUM + 1);
    localparam int KW     = $clog2(PROC_NUM + 1);

    dl_state_t           state;
    logic [PROC_NUM-1:0] last_scan, mark, ptr, token;
    logic [CIDX_W-1:0]   cand;
    logic [KW-1:0]       k;
    logic                walking;
    logic                freeze;

    logic [PROC_NUM-1:0] cand_oh, nxt_cand, nxt_ptr, mark_n, token_n;
    logic                abort, hit, cand_done;

    // Freezing keeps the flagged circle intact for the whole report phase.
    assign freeze = (state == S_FLAG) || (state == S_WALK);

    for (genvar g = 0; g < PROC_NUM; g++) begin : g_cnt
        dl_stall_counter #(
            .STALL_CYCLES(STALL_CYCLES),
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .blocked(proc_blocked[g]),
            .freeze (freeze),
            .stalled(stall_vec[g])
        );
    end

    // One hop along the wait-for graph, restricted to stalled processes.
    function automatic logic [PROC_NUM-1:0] nxt(input logic [PROC_NUM-1:0] x);
        logic [PROC_NUM-1:0] row;
        logic [MAX_PROC-1:0] ext;
        row = '0;
        for (int i = 0; i < PROC_NUM; i++)
            if (x[i]) row = row | dep_vec[i*PROC_NUM +: PROC_NUM];
        ext = '0;
        ext[PROC_NUM-1:0] = row & stall_vec;
        ext = first_one_hot(ext);
        return ext[PROC_NUM-1:0];
    endfunction

    // origin and token_clear are single-cycle strobes from the report unit with
    // no back-pressure; token_clear wins when both arrive together.
    always_comb begin
        cand_oh = '0;
        for (int i = 0; i < PROC_NUM; i++) cand_oh[i] = (cand == CIDX_W'(i));
        nxt_cand  = nxt(cand_oh);
        nxt_ptr   = nxt(ptr);
        abort     = |(last_scan & ~stall_vec);
        hit       = walking && (ptr == cand_oh);
        cand_done = walking ? (hit || ptr == '0 || k == KW'(PROC_NUM))
                            : !(|(stall_vec & cand_oh));
        mark_n    = hit ? (mark | cand_oh) : mark;
        if (token_clear)      token_n = '0;
        else if (origin != '0) token_n = nxt(origin);
        else if (token != '0)  token_n = nxt(token);
        else                   token_n = token;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_MONITOR;
            last_scan <= '0;
            mark      <= '0;
            cand      <= '0;
            ptr       <= '0;
            k         <= '0;
            walking   <= 1'b0;
            token     <= '0;
            dl_in_vec <= '0;
            scan_busy <= 1'b0;
        end else begin
            case (state)
                S_MONITOR: begin
                    if (stall_vec != '0 && stall_vec != last_scan) begin
                        last_scan <= stall_vec;
                        cand      <= '0;
                        mark      <= '0;
                        walking   <= 1'b0;
                        scan_busy <= 1'b1;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        last_scan <= '0;
                        scan_busy <= 1'b0;
                        state     <= S_MONITOR;
                    end else if (cand_done) begin
                        mark    <= mark_n;
                        walking <= 1'b0;
                        if (cand == CIDX_W'(PROC_NUM - 1)) begin
                            scan_busy <= 1'b0;
                            if (mark_n != '0) begin
                                dl_in_vec <= mark_n;
                                state     <= S_FLAG;
                            end else begin
                                state <= S_MONITOR;
                            end
                        end else begin
                            cand <= cand + CIDX_W'(1);
                        end
                    end else if (!walking) begin
                        ptr     <= nxt_cand;
                        k       <= KW'(1);
                        walking <= 1'b1;
                    end else begin
                        ptr <= nxt_ptr;
                        k   <= k + KW'(1);
                    end
                end
                S_FLAG: begin
                    dl_in_vec <= token;
                    state     <= S_WALK;
                end
                S_WALK: begin
                    token     <= token_n;
                    dl_in_vec <= token_n;
                end
                default: state <= S_MONITOR;
            endcase
        end
    end

endmodule

// File: tb/tb_dl_stall_cycle_detector.sv
// Bench for the stall circle detector: directed scenarios on 2- and 3-process
// instances plus randomized wait-for graphs checked against a graph model.
module tb_dl_stall_cycle_detector;

    logic       clock;
    logic       reset2, reset3;
    logic [1:0] blocked2, origin2, dl2, stall2;
    logic [3:0] dep2;
    logic       clear2, busy2;
    logic [2:0] blocked3, origin3, dl3, stall3;
    logic [8:0] dep3;
    logic       clear3, busy3;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    dl_stall_cycle_detector #(.PROC_NUM(2), .STALL_CYCLES(4), .CNT_W(16)) dut2 (
        .clock(clock), .reset(reset2), .proc_blocked(blocked2), .dep_vec(dep2),
        .origin(origin2), .token_clear(clear2), .dl_in_vec(dl2),
        .stall_vec(stall2), .scan_busy(busy2)
    );

    dl_stall_cycle_detector #(.PROC_NUM(3), .STALL_CYCLES(4), .CNT_W(16)) dut3 (
        .clock(clock), .reset(reset3), .proc_blocked(blocked3), .dep_vec(dep3),
        .origin(origin3), .token_clear(clear3), .dl_in_vec(dl3),
        .stall_vec(stall3), .scan_busy(busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: index of the lowest stalled process that i waits on, -1 if none.
    function automatic int m_nxt(input int np, input logic [8:0] dep, input logic [2:0] stl, input int i);
        for (int j = 0; j < np; j++)
            if (dep[i*np+j] && stl[j]) return j;
        return -1;
    endfunction

    // Reference: stalled processes that return to themselves within np hops.
    function automatic logic [2:0] m_circle(input int np, input logic [8:0] dep, input logic [2:0] stl);
        logic [2:0] r;
        int p;
        r = '0;
        for (int i = 0; i < np; i++) begin
            if (stl[i]) begin
                p = m_nxt(np, dep, stl, i);
                for (int s = 1; s <= np && p >= 0; s++) begin
                    if (p == i) begin
                        r[i] = 1'b1;
                        break;
                    end
                    p = m_nxt(np, dep, stl, p);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] cur_dl(input int which);
        return (which == 2) ? {1'b0, dl2} : dl3;
    endfunction

    task automatic set_origin(input int which, input logic [2:0] v);
        if (which == 2) origin2 = v[1:0];
        else origin3 = v;
    endtask

    task automatic set_clear(input int which, input logic v);
        if (which == 2) clear2 = v;
        else clear3 = v;
    endtask

    task automatic wait_flag(input int which, input int budget, output logic [2:0] val, output bit found);
        found = 1'b0;
        val   = '0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clock);
            if (cur_dl(which) != 3'b000) begin
                found = 1'b1;
                val   = cur_dl(which);
            end
        end
    endtask

    // Drive origin for one cycle, then compare successive walk tokens.
    task automatic do_walk(input int which, input int np, input logic [8:0] dep,
                           input logic [2:0] stl, input int start, input int steps);
        int cur;
        cur = start;
        for (int s = 0; s < steps; s++) begin
            cur = (cur < 0) ? -1 : m_nxt(np, dep, stl, cur);
            exp_q.push_back((cur < 0) ? 3'b000 : 3'(1 << cur));
        end
        set_origin(which, 3'(1 << start));
        @(negedge clock);
        set_origin(which, 3'b000);
        for (int s = 0; s < steps; s++) begin
            check_eq($sformatf("walk%0d_step%0d", which, s), cur_dl(which), exp_q.pop_front());
            @(negedge clock);
        end
    endtask

    task automatic do_clear(input int which);
        set_clear(which, 1'b1);
        @(negedge clock);
        set_clear(which, 1'b0);
        check_eq("clear_token", cur_dl(which), 3'b000);
        @(negedge clock);
        check_eq("clear_hold", cur_dl(which), 3'b000);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        logic [2:0] val, exp_mark;
        bit found, fell;
        int nz, rises, prev_busy, pick;

        blocked2 = '0; dep2 = '0; origin2 = '0; clear2 = 1'b0;
        blocked3 = '0; dep3 = '0; origin3 = '0; clear3 = 1'b0;
        reset2 = 1'b0; reset3 = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_dl2", dl2, 2'b00);
        check_eq("rst_stall2", stall2, 2'b00);
        check_eq("rst_busy2", busy2, 1'b0);
        check_eq("rst_dl3", dl3, 3'b000);
        reset2 = 1'b1; reset3 = 1'b1;

        // Mutual wait between two processes.
        blocked2 = 2'b11; dep2 = 4'b0110;
        repeat (3) @(negedge clock);
        check_eq("mut_stall_early", stall2, 2'b00);
        @(negedge clock);
        check_eq("mut_stall", stall2, 2'b11);
        wait_flag(2, 12, val, found);
        check_eq("mut_flag_found", found, 1'b1);
        check_eq("mut_flag", val, m_circle(2, {5'b0, dep2}, stall2));
        @(negedge clock);
        check_eq("mut_flag_one_cycle", dl2, 2'b00);
        do_walk(2, 2, {5'b0, dep2}, 3'b011, 0, 3);
        do_clear(2);
        // Clear and origin together: clear must win.
        origin2 = 2'b01; clear2 = 1'b1;
        @(negedge clock);
        origin2 = 2'b00; clear2 = 1'b0;
        check_eq("clear_beats_origin", dl2, 2'b00);

        // Asynchronous reset in the middle of a walk.
        origin2 = 2'b01;
        @(negedge clock);
        origin2 = 2'b00;
        check_eq("prewalk_token", dl2, 2'b10);
        #2 reset2 = 1'b0;
        #1;
        check_eq("async_rst_dl", dl2, 2'b00);
        check_eq("async_rst_stall", stall2, 2'b00);
        check_eq("async_rst_busy", busy2, 1'b0);
        @(negedge clock);
        reset2 = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("post_rst_stall_early", stall2, 2'b00);
        @(negedge clock);
        check_eq("post_rst_stall", stall2, 2'b11);
        wait_flag(2, 12, val, found);
        check_eq("post_rst_flag", val, 3'b011);

        // Short stall never reaches the threshold.
        reset2 = 1'b0; blocked2 = 2'b00;
        @(negedge clock);
        reset2 = 1'b1;
        blocked2 = 2'b11;
        repeat (3) @(negedge clock);
        blocked2 = 2'b00;
        nz = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (stall2 != 2'b00 || busy2) nz++;
        end
        check_eq("short_stall_quiet", nz, 0);

        // No circle: one stalled process waiting on an idle one.
        reset2 = 1'b0;
        @(negedge clock);
        reset2 = 1'b1;
        blocked2 = 2'b01; dep2 = 4'b0010;
        nz = 0; rises = 0; prev_busy = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (dl2 != 2'b00) nz++;
            if (busy2 && prev_busy == 0) rises++;
            prev_busy = busy2;
        end
        check_eq("nocircle_dl", nz, 0);
        check_eq("nocircle_scans", rises, 1);

        // Abort: one process unblocks while the scan runs.
        reset2 = 1'b0; blocked2 = 2'b00;
        @(negedge clock);
        reset2 = 1'b1;
        blocked2 = 2'b11; dep2 = 4'b0110;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clock);
            found = busy2;
        end
        check_eq("abort_scan_seen", found, 1'b1);
        blocked2 = 2'b01;
        fell = 1'b0; nz = 0;
        for (int c = 0; c < 4 && !fell; c++) begin
            @(negedge clock);
            if (dl2 != 2'b00) nz++;
            fell = !busy2;
        end
        check_eq("abort_busy_fell", fell, 1'b1);
        check_eq("abort_stall", stall2, 2'b01);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (dl2 != 2'b00) nz++;
        end
        check_eq("abort_no_flag", nz, 0);
        blocked2 = 2'b11;
        wait_flag(2, 30, val, found);
        check_eq("abort_reflag_found", found, 1'b1);
        check_eq("abort_reflag", val, 3'b011);

        // Open chain into a two-process circle.
        blocked3 = 3'b111; dep3 = 9'b010_100_010;
        wait_flag(3, 30, val, found);
        check_eq("chain_flag_found", found, 1'b1);
        check_eq("chain_flag", val, m_circle(3, dep3, 3'b111));
        @(negedge clock);
        do_walk(3, 3, dep3, 3'b111, 1, 3);
        do_clear(3);

        // Randomized wait-for graphs.
        for (int t = 0; t < 16; t++) begin
            reset3 = 1'b0;
            blocked3 = 3'($urandom_range(0, 7));
            dep3 = 9'($urandom_range(0, 511));
            @(negedge clock);
            reset3 = 1'b1;
            repeat (5) @(negedge clock);
            check_eq($sformatf("rnd%0d_stall", t), stall3, blocked3);
            exp_mark = m_circle(3, dep3, blocked3);
            wait_flag(3, 30, val, found);
            check_eq($sformatf("rnd%0d_found", t), found, (exp_mark != 3'b000));
            if (exp_mark != 3'b000) begin
                check_eq($sformatf("rnd%0d_flag", t), val, exp_mark);
                @(negedge clock);
                pick = $urandom_range(0, 2);
                while (!exp_mark[pick]) pick = (pick + 1) % 3;
                do_walk(3, 3, dep3, blocked3, pick, 4);
                do_clear(3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
